// File: rtl/debounce_multi.sv
// debounce_multi: N independent switch debouncers.
// Each channel has a 2-flop synchronizer, then a per-channel stability counter.
// A channel's debounced level (led) changes only after the synchronized input
// has held the new level for STABLE_CYCLES consecutive clocks.
// reset_n is synchronous and active-high (asserted = 1).
// Optional macro DEBOUNCE_EDGE_EN: when defined, registered one-cycle rise/fall
// pulses are produced on accepted edges; otherwise rise/fall are tied to 0.
module debounce_multi #(
  parameter int unsigned N             = 8,
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned CNT_W         = 20
) (
  input  logic         fpga_clk,
  input  logic         reset_n,
  input  logic [N-1:0] sw,
  output logic [N-1:0] led,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [N-1:0]     s1_q, s1_d;
  logic [N-1:0]     s2_q, s2_d;
  logic [N-1:0]     stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];

  // Synchronizer shift and per-channel qualification counters.
  always_comb begin
    s1_d     = sw;
    s2_d     = s1_q;
    stable_d = stable_q;
    for (int i = 0; i < int'(N); i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= CNT_MAX) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge fpga_clk) begin
    if (reset_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      for (int i = 0; i < int'(N); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      for (int i = 0; i < int'(N); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign led = stable_q;

`ifdef DEBOUNCE_EDGE_EN
  logic [N-1:0] rise_q, rise_d;
  logic [N-1:0] fall_q, fall_d;

  // Edge pulses coincide with the edge on which stable changes.
  always_comb begin
    rise_d = stable_d & ~stable_q;
    fall_d = ~stable_d & stable_q;
  end

  // Edge pulse registers.
  always_ff @(posedge fpga_clk) begin
    if (reset_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi (N=4, STABLE_CYCLES=8, CNT_W=4).
// A history-window model predicts led/rise/fall every cycle; directed
// literal checks pin the key latencies.
module tb_debounce_multi;

  localparam int unsigned N  = 4;
  localparam int unsigned SC = 8;
  localparam int unsigned CW = 4;

`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic         fpga_clk;
  logic         reset_n;
  logic [N-1:0] sw;
  logic [N-1:0] led;
  logic [N-1:0] rise;
  logic [N-1:0] fall;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit run_chk   = 1'b0;

  debounce_multi #(
    .N            (N),
    .STABLE_CYCLES(SC),
    .CNT_W        (CW)
  ) dut (
    .fpga_clk(fpga_clk),
    .reset_n (reset_n),
    .sw      (sw),
    .led     (led),
    .rise    (rise),
    .fall    (fall)
  );

  initial fpga_clk = 1'b0;
  always #5 fpga_clk = ~fpga_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [N-1:0] edge_exp(input logic [N-1:0] v);
    return EDGE_EN ? v : '0;
  endfunction

  // Model: sw reaches the filter two edges after being sampled; a channel's
  // level flips when the last SC filter samples all disagree with it.
  logic [N-1:0] p1, p2;
  logic [N-1:0] hist [SC];
  int           wr;
  logic [N-1:0] exp_led, exp_rise, exp_fall;

  initial begin
    p1 = '0; p2 = '0; wr = 0;
    exp_led = '0; exp_rise = '0; exp_fall = '0;
    for (int j = 0; j < int'(SC); j++) hist[j] = '0;
  end

  always @(posedge fpga_clk) begin
    logic [N-1:0] sv;
    bit all_diff;
    if (reset_n) begin
      p1 = '0; p2 = '0; wr = 0;
      for (int j = 0; j < int'(SC); j++) hist[j] = '0;
      exp_led = '0; exp_rise = '0; exp_fall = '0;
    end else begin
      sv = p2;
      p2 = p1;
      p1 = sw;
      hist[wr] = sv;
      wr = (wr + 1) % int'(SC);
      exp_rise = '0;
      exp_fall = '0;
      for (int i = 0; i < int'(N); i++) begin
        all_diff = 1'b1;
        for (int j = 0; j < int'(SC); j++)
          if (hist[j][i] == exp_led[i]) all_diff = 1'b0;
        if (all_diff) begin
          exp_led[i] = ~exp_led[i];
          if (EDGE_EN) begin
            if (exp_led[i]) exp_rise[i] = 1'b1;
            else            exp_fall[i] = 1'b1;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge fpga_clk) begin
    if (run_chk) begin
      check("model_led",  32'(led),  32'(exp_led));
      check("model_rise", 32'(rise), 32'(exp_rise));
      check("model_fall", 32'(fall), 32'(exp_fall));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge fpga_clk);
    #1;
  endtask

  task automatic set_sw(input logic [N-1:0] v);
    @(negedge fpga_clk);
    sw = v;
  endtask

  initial begin
    reset_n = 1'b1;
    sw      = 4'hF;

    // Reset held three cycles with all switches high.
    for (int c = 0; c < 3; c++) begin
      tick(1);
      run_chk = 1'b1;
      check("rst_led",  32'(led),  32'h0);
      check("rst_rise", 32'(rise), 32'h0);
      check("rst_fall", 32'(fall), 32'h0);
    end
    @(negedge fpga_clk);
    reset_n = 1'b0;
    tick(9);
    check("rel_led_k8", 32'(led), 32'h0);
    tick(1);
    check("rel_led_k9",  32'(led),  32'hF);
    check("rel_rise_k9", 32'(rise), 32'(edge_exp(4'hF)));
    tick(1);
    check("rel_rise_k10", 32'(rise), 32'h0);

    // Clean single-channel step.
    set_sw(4'h0);
    tick(12);
    check("settle0_led", 32'(led), 32'h0);
    set_sw(4'b0001);
    tick(9);
    check("step_led_k8", 32'(led), 32'h0);
    tick(1);
    check("step_led_k9",  32'(led),  32'h1);
    check("step_rise_k9", 32'(rise), 32'(edge_exp(4'b0001)));
    check("step_fall_k9", 32'(fall), 32'h0);
    tick(1);
    check("step_rise_k10", 32'(rise), 32'h0);

    // One-cycle glitches on channel 1 every third cycle.
    for (int c = 0; c < 40; c++) begin
      @(negedge fpga_clk);
      sw[1] = (c % 3 == 0);
    end
    set_sw(4'b0001);
    tick(12);
    check("glitch_led", 32'(led), 32'h1);

    // Seven-cycle burst (one short of qualifying), then a held level.
    set_sw(4'b0101);
    repeat (7) @(negedge fpga_clk);
    sw[2] = 1'b0;
    repeat (5) @(negedge fpga_clk);
    sw[2] = 1'b1;
    tick(9);
    check("burst_led_k8", 32'(led), 32'b0001);
    tick(1);
    check("burst_led_k9", 32'(led), 32'b0101);

    // Complementary pattern swap: all four channels flip together.
    set_sw(4'b0101);
    tick(12);
    check("swap_pre_led", 32'(led), 32'b0101);
    set_sw(4'b1010);
    tick(9);
    check("swap_led_k8", 32'(led), 32'b0101);
    tick(1);
    check("swap_led_k9",  32'(led),  32'b1010);
    check("swap_rise_k9", 32'(rise), 32'(edge_exp(4'b1010)));
    check("swap_fall_k9", 32'(fall), 32'(edge_exp(4'b0101)));
    tick(1);
    check("swap_rise_k10", 32'(rise), 32'h0);
    check("swap_fall_k10", 32'(fall), 32'h0);

    // Reset in the middle of a qualification discards the partial count.
    set_sw(4'h0);
    tick(12);
    set_sw(4'b1000);
    tick(5);
    @(negedge fpga_clk);
    reset_n = 1'b1;
    tick(2);
    check("midrst_led", 32'(led), 32'h0);
    @(negedge fpga_clk);
    reset_n = 1'b0;
    tick(9);
    check("midrst_led_k8", 32'(led), 32'h0);
    tick(1);
    check("midrst_led_k9",  32'(led),  32'b1000);
    check("midrst_rise_k9", 32'(rise), 32'(edge_exp(4'b1000)));
    tick(3);

    run_chk = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
